// File: rtl/uart_cmd_ctrl_if.sv
// Purpose : bundles the byte-receive strobe and the register-access / status
//           outputs of uart_cmd_ctrl into one port.
// Ports   : rx_byte/rx_en in; wr_en/wr_addr/wr_data, rd_req/rd_addr,
//           frame_err/err_cnt/busy out (slave = controller side).
interface uart_cmd_ctrl_if;
    logic [7:0] rx_byte;
    logic       rx_en;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_req;
    logic [7:0] rd_addr;
    logic       frame_err;
    logic [7:0] err_cnt;
    logic       busy;

    // Controller side.
    modport slave (
        input  rx_byte, rx_en,
        output wr_en, wr_addr, wr_data, rd_req, rd_addr, frame_err, err_cnt, busy
    );

    // UART receiver / register-file side.
    modport master (
        output rx_byte, rx_en,
        input  wr_en, wr_addr, wr_data, rd_req, rd_addr, frame_err, err_cnt, busy
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Purpose : parses SOF,CMD,ADDR,[DATA],CHK byte frames into register write/read strobes.
// Latency : strobe (wr_en/rd_req/frame_err) is high the cycle after the CHK byte is sampled.
// Backpr. : none; every rx_en byte is consumed, back-to-back frames accepted with zero bubble.
// Ports   : clk, rst (sync, active-high), bus (uart_cmd_ctrl_if.slave).
module uart_cmd_ctrl #(
    parameter logic [7:0]  SOF     = 8'hA5,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    uart_cmd_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_CHK
    } state_t;

    localparam logic [7:0]  CMD_WR  = 8'h01;
    localparam logic [7:0]  CMD_RD  = 8'h02;
    // Value of the idle counter on the last quiet cycle allowed before timeout.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] idle_q, idle_d;
    logic        is_wr_q, is_wr_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  chk_q, chk_d;          // running XOR of CMD/ADDR/DATA
    logic        wr_en_q, wr_en_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        rd_req_q, rd_req_d;
    logic [7:0]  rd_addr_q, rd_addr_d;
    logic        frame_err_q, frame_err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        idle_d      = idle_q;
        is_wr_d     = is_wr_q;
        addr_d      = addr_q;
        data_d      = data_q;
        chk_d       = chk_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_req_d    = 1'b0;
        rd_addr_d   = rd_addr_q;
        frame_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;

        if (bus.rx_en) begin
            // A received byte always wins over a timeout firing in the same cycle.
            idle_d = '0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.rx_byte == SOF) begin
                        state_d = S_CMD;
                    end
                end
                S_CMD: begin
                    if (bus.rx_byte == CMD_WR || bus.rx_byte == CMD_RD) begin
                        is_wr_d = (bus.rx_byte == CMD_WR);
                        chk_d   = bus.rx_byte;
                        state_d = S_ADDR;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
                S_ADDR: begin
                    addr_d  = bus.rx_byte;
                    chk_d   = chk_q ^ bus.rx_byte;
                    state_d = is_wr_q ? S_DATA : S_CHK;
                end
                S_DATA: begin
                    data_d  = bus.rx_byte;
                    chk_d   = chk_q ^ bus.rx_byte;
                    state_d = S_CHK;
                end
                S_CHK: begin
                    if (bus.rx_byte == chk_q) begin
                        if (is_wr_q) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = data_q;
                        end else begin
                            rd_req_d  = 1'b1;
                            rd_addr_d = addr_q;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (idle_q == TO_LAST) begin
                frame_err_d = 1'b1;
                state_d     = S_IDLE;
                idle_d      = '0;
            end else begin
                idle_d = idle_q + 16'd1;
            end
        end

        if (frame_err_d && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idle_q      <= '0;
            is_wr_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            chk_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= '0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idle_q      <= idle_d;
            is_wr_q     <= is_wr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            chk_q       <= chk_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_req_q    <= rd_req_d;
            rd_addr_q   <= rd_addr_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.rd_req    = rd_req_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Purpose : scoreboard bench for uart_cmd_ctrl; expected strobes are queued as frames are sent.
// Latency : strobes are matched one cycle after the completing byte.
// Backpr. : none; bytes are driven back-to-back or with chosen idle gaps.
module tb_uart_cmd_ctrl;

    localparam int TIMEOUT = 64;

    typedef struct {
        logic [1:0] kind;     // 0 write, 1 read, 2 error
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] err_cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_cmd_ctrl_if bus();

    uart_cmd_ctrl #(.SOF(8'hA5), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t       sb_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_err_cnt = 8'd0;
    logic [2:0] prev_strb = 3'b000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic [7:0] addr, input logic [7:0] data);
        exp_t e;
        if (kind == 2'd2 && exp_err_cnt != 8'hFF) exp_err_cnt++;
        e.kind = kind; e.addr = addr; e.data = data; e.err_cnt = exp_err_cnt;
        sb_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_byte = b;
        bus.rx_en   = 1'b1;
        @(posedge clk); #1;
        bus.rx_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: compare every strobe against the head of the scoreboard.
    always @(negedge clk) begin
        logic [2:0] strb;
        exp_t e;
        strb = {bus.frame_err, bus.rd_req, bus.wr_en};
        if (!rst) begin
            if (strb != 3'b000) begin
                check("strobe_excl", {31'd0, $countones(strb) > 1}, 32'd0);
                check("pulse_len", {29'd0, strb & prev_strb}, 32'd0);
                if (sb_q.size() == 0) begin
                    check("spurious_strobe", {29'd0, strb}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    case (e.kind)
                        2'd0: begin
                            check("wr_en", {31'd0, bus.wr_en}, 32'd1);
                            check("wr_addr", {24'd0, bus.wr_addr}, {24'd0, e.addr});
                            check("wr_data", {24'd0, bus.wr_data}, {24'd0, e.data});
                        end
                        2'd1: begin
                            check("rd_req", {31'd0, bus.rd_req}, 32'd1);
                            check("rd_addr", {24'd0, bus.rd_addr}, {24'd0, e.addr});
                        end
                        default: check("frame_err", {31'd0, bus.frame_err}, 32'd1);
                    endcase
                    check("err_cnt", {24'd0, bus.err_cnt}, {24'd0, e.err_cnt});
                end
            end
        end
        prev_strb <= strb;
    end

    initial begin
        bus.rx_byte = 8'h00;
        bus.rx_en   = 1'b0;
        idle(3);
        check("rst_outs", {29'd0, bus.wr_en, bus.rd_req, bus.frame_err}, 32'd0);
        check("rst_addr", {8'd0, bus.wr_addr, bus.wr_data, bus.rd_addr}, 32'd0);
        check("rst_cnt_busy", {23'd0, bus.err_cnt, bus.busy}, 32'd0);
        rst = 1'b0;
        idle(2);

        // Write frame.
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10); send_byte(8'h3C);
        push(2'd0, 8'h10, 8'h3C);
        send_byte(8'h2D);
        idle(3);
        check("wr_hold_addr", {24'd0, bus.wr_addr}, 32'h10);
        check("wr_hold_data", {24'd0, bus.wr_data}, 32'h3C);

        // Read frame followed immediately by another write (zero bubble).
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h20);
        push(2'd1, 8'h20, 8'h00);
        send_byte(8'h22);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'hA5); send_byte(8'h5A);
        push(2'd0, 8'hA5, 8'h5A);
        send_byte(8'hFE);               // 01^A5^5A, SOF value inside a frame is data
        idle(3);
        check("rd_hold_addr", {24'd0, bus.rd_addr}, 32'h20);

        // Bad checksum, then bad command.
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10); send_byte(8'h3C);
        push(2'd2, 8'h00, 8'h00);
        send_byte(8'h00);
        send_byte(8'hA5);
        push(2'd2, 8'h00, 8'h00);
        send_byte(8'h07);
        idle(3);
        check("err_cnt_2", {24'd0, bus.err_cnt}, 32'd2);

        // Stray byte, partial frame, then timeout.
        send_byte(8'h55);
        check("busy_after_junk", {31'd0, bus.busy}, 32'd0);
        send_byte(8'hA5);
        check("busy_in_frame", {31'd0, bus.busy}, 32'd1);
        send_byte(8'h01);
        push(2'd2, 8'h00, 8'h00);
        idle(TIMEOUT);
        check("busy_after_to", {31'd0, bus.busy}, 32'd0);
        idle(2);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h33);
        push(2'd1, 8'h33, 8'h00);
        send_byte(8'h31);
        idle(3);

        // Byte arriving on the last allowed quiet cycle is processed, no timeout.
        send_byte(8'hA5); send_byte(8'h02);
        idle(TIMEOUT - 1);
        send_byte(8'h44);
        idle(TIMEOUT - 1);
        push(2'd1, 8'h44, 8'h00);
        send_byte(8'h46);
        idle(3);

        // Reset mid-frame, with a byte colliding with the reset cycle.
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
        rst = 1'b1;
        send_byte(8'h3C);
        rst = 1'b0;
        exp_err_cnt = 8'd0;
        check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_mid_cnt", {24'd0, bus.err_cnt}, 32'd0);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h05);
        push(2'd1, 8'h05, 8'h00);
        send_byte(8'h07);
        idle(3);

        // Saturation of the error counter.
        for (int i = 0; i < 256; i++) begin
            send_byte(8'hA5);
            push(2'd2, 8'h00, 8'h00);
            send_byte(8'h07);
        end
        idle(3);
        check("err_cnt_sat", {24'd0, bus.err_cnt}, 32'hFF);

        idle(5);
        check("sb_drain", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
